// File: rtl/snn_image_loader_pkg.sv
// Shared constants and FSM state type for the SNN image loader.
package snn_image_loader_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NUM_BYTES  = NUM_PIXELS / BYTE_W;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned SEL_W      = $clog2(BYTE_W);
  localparam int unsigned BIDX_W     = ADDR_W - SEL_W;

  typedef enum logic [1:0] {StLoad, StKick, StRun, StResult} loader_state_t;

endpackage

// File: rtl/snn_image_loader_if.sv
// Byte streams and snn_core handshake bundled between host/core side and the loader.
interface snn_image_loader_if;
  import snn_image_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic [ADDR_W-1:0] addr_input_unit;
  logic              q_input;
  logic              done;
  logic [3:0]        digit;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  modport slave (
    input  rx_data, rx_valid, addr_input_unit, done, digit, tx_ready,
    output rx_ready, start, q_input, tx_data, tx_valid, busy
  );

  modport master (
    output rx_data, rx_valid, addr_input_unit, done, digit, tx_ready,
    input  rx_ready, start, q_input, tx_data, tx_valid, busy
  );

endinterface

// File: rtl/snn_img_buf.sv
// Image byte RAM: one byte write port, registered single-bit read port.
module snn_img_buf
  import snn_image_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [BIDX_W-1:0] wr_idx_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_bit_o
);

  logic [BYTE_W-1:0] mem_q [NUM_BYTES];
  logic [BIDX_W-1:0] rd_idx;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_bit_d, rd_bit_q;

  assign rd_idx = rd_addr_i[ADDR_W-1:SEL_W];
  assign rd_sel = rd_addr_i[SEL_W-1:0];

  // Storage is never cleared: reset only discards the partially received image.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_bit_d = 1'b0;
    if (rd_addr_i < ADDR_W'(NUM_PIXELS)) begin
      rd_bit_d = mem_q[rd_idx][rd_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bit_q <= 1'b0;
    end else begin
      rd_bit_q <= rd_bit_d;
    end
  end

  assign rd_bit_o = rd_bit_q;

endmodule

// File: rtl/snn_image_loader.sv
// Host endpoint for snn_core: load image bytes, kick core, serve pixels, return digit.
// Define SNN_ASCII_DIGIT_EN to return the digit as ASCII ('0' + digit).
module snn_image_loader
  import snn_image_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  snn_image_loader_if.slave  bus
);

  loader_state_t     state_q;
  logic [BIDX_W-1:0] byte_cnt_q;
  logic              rx_ready_q;
  logic              start_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic              busy_q;
  logic              rx_fire;
  logic              last_byte;

  function automatic logic [7:0] digit_byte(input logic [3:0] d);
`ifdef SNN_ASCII_DIGIT_EN
    return 8'h30 + {4'h0, d};
`else
    return {4'h0, d};
`endif
  endfunction

  // rx_ready_q is high exactly in StLoad, so it gates buffer writes to that state.
  assign rx_fire   = bus.rx_valid & rx_ready_q;
  assign last_byte = (byte_cnt_q == BIDX_W'(NUM_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      byte_cnt_q <= '0;
      rx_ready_q <= 1'b1;
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (rx_fire) begin
            if (last_byte) begin
              byte_cnt_q <= '0;
              rx_ready_q <= 1'b0;
              start_q    <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= StKick;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StKick: state_q <= StRun;
        StRun: begin
          if (bus.done) begin
            tx_data_q  <= digit_byte(bus.digit);
            tx_valid_q <= 1'b1;
            state_q    <= StResult;
          end
        end
        StResult: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  snn_img_buf u_img_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (rx_fire),
    .wr_idx_i  (byte_cnt_q),
    .wr_data_i (bus.rx_data),
    .rd_addr_i (bus.addr_input_unit),
    .rd_bit_o  (bus.q_input)
  );

  assign bus.rx_ready = rx_ready_q;
  assign bus.start    = start_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;

endmodule
